// File: rtl/srv1_pkg.sv
// Types and lane-order constants shared by the store path and the load-data adjuster.
// Bus lane 0 is [31:24] and holds the byte at address offset 0.
package srv1_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_e;

    typedef logic [3:0] wstrb_t;

    typedef struct packed {
        logic [29:0] addr_w;
        logic [31:0] wdata;
        wstrb_t      wstrb;
    } store_entry_t;

    // Strobe bit 3 is lane [31:24], i.e. the byte at offset 0.
    localparam wstrb_t STRB_LANE0   = 4'b1000;
    localparam wstrb_t STRB_HALF_LO = 4'b1100;
    localparam wstrb_t STRB_HALF_HI = 4'b0011;
    localparam wstrb_t STRB_WORD    = 4'b1111;

    function automatic mem_size_e size_from_fn3(input logic [1:0] f);
        case (f)
            2'd0:    return BYTE;
            2'd1:    return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic [15:0] lane_swap16(input logic [15:0] d);
        return {d[7:0], d[15:8]};
    endfunction

    function automatic logic [31:0] lane_swap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/store_unit_output_adj.sv
// Combinational store formatter: register data to bus lane order plus byte strobes.
// Mirror image of the load adjuster; flags misaligned halves and words.
module output_adj
    import srv1_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  fn3,
    input  logic [1:0]  addr_low,
    output logic [31:0] wdata,
    output wstrb_t      wstrb,
    output logic        misalign
);

    // Only the size bits matter; bit 2 (unsigned flag) is meaningless for stores.
    logic unused_fn3;
    assign unused_fn3 = fn3[2];

    always_comb begin
        wdata    = '0;
        wstrb    = '0;
        misalign = 1'b0;
        case (size_from_fn3(fn3[1:0]))
            BYTE: begin
                wdata = {4{data_in[7:0]}};
                wstrb = STRB_LANE0 >> addr_low;
            end
            HALF: begin
                if (addr_low[0]) begin
                    misalign = 1'b1;
                end else if (addr_low[1]) begin
                    wdata = {16'h0, lane_swap16(data_in[15:0])};
                    wstrb = STRB_HALF_HI;
                end else begin
                    wdata = {lane_swap16(data_in[15:0]), 16'h0};
                    wstrb = STRB_HALF_LO;
                end
            end
            default: begin
                if (addr_low != 2'b00) begin
                    misalign = 1'b1;
                end else begin
                    wdata = lane_swap32(data_in);
                    wstrb = STRB_WORD;
                end
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store path: formats requests, queues aligned stores in a small FIFO and
// posts them to the data bus one at a time through a two-state bus FSM.
module store_unit
    import srv1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [2:0]  st_fn3,
    output logic        st_misalign,
    output logic        st_busy,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic        mem_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic        bus_err,
    output logic [31:0] bus_err_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE, S_REQ} bus_state_e;

    store_entry_t  fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    bus_state_e    state;

    logic [31:0]   adj_wdata;
    wstrb_t        adj_wstrb;
    logic          adj_misalign;
    logic          full;
    logic          accept;
    logic          push;
    logic          pop;
    store_entry_t  push_entry;
    store_entry_t  next_head;

    output_adj u_adj (
        .data_in  (st_data),
        .fn3      (st_fn3),
        .addr_low (st_addr[1:0]),
        .wdata    (adj_wdata),
        .wstrb    (adj_wstrb),
        .misalign (adj_misalign)
    );

    assign full       = (count == CW'(DEPTH));
    assign st_ready   = !full;
    assign accept     = st_valid & st_ready;
    assign push       = accept & !adj_misalign;
    assign pop        = (state == S_REQ) & mem_ack;
    assign st_busy    = (count != '0) | (state == S_REQ);
    assign push_entry = '{addr_w: st_addr[31:2], wdata: adj_wdata, wstrb: adj_wstrb};

    // With one entry left and a push on the same edge, the pushed entry becomes the
    // head before it is visible in the array, so forward it directly.
    assign next_head  = (count > CW'(1)) ? fifo_mem[rd_ptr + PW'(1)] : push_entry;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            state        <= S_IDLE;
            st_misalign  <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            bus_err      <= 1'b0;
            bus_err_addr <= '0;
        end else begin
            st_misalign <= accept & adj_misalign;
            bus_err     <= pop & mem_err;
            if (pop & mem_err) begin
                bus_err_addr <= mem_addr;
            end

            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // Bus payload is registered so it stays stable for the whole request.
            case (state)
                S_IDLE: begin
                    if (count != '0) begin
                        state     <= S_REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= {fifo_mem[rd_ptr].addr_w, 2'b00};
                        mem_wdata <= fifo_mem[rd_ptr].wdata;
                        mem_wstrb <= fifo_mem[rd_ptr].wstrb;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        if ((count > CW'(1)) || push) begin
                            mem_addr  <= {next_head.addr_w, 2'b00};
                            mem_wdata <= next_head.wdata;
                            mem_wstrb <= next_head.wstrb;
                        end else begin
                            state   <= S_IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed self-checking bench for store_unit: a formatter vector table driven
// through the full store path, then hand-written FIFO, bus-error and reset sequences.
module tb_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_fn3;
    logic        st_misalign;
    logic        st_busy;
    logic        mem_req;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  fn3;
        logic        mis;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
    } vec_t;

    vec_t vecs [10];

    store_unit #(.DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_valid     (st_valid),
        .st_ready     (st_ready),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_fn3       (st_fn3),
        .st_misalign  (st_misalign),
        .st_busy      (st_busy),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .mem_err      (mem_err),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .bus_err      (bus_err),
        .bus_err_addr (bus_err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] fn3);
        st_valid = 1'b1;
        st_addr  = addr;
        st_data  = data;
        st_fn3   = fn3;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_st_ready"},     32'(st_ready),     32'd1);
        checkOutput({tag, "_st_misalign"},  32'(st_misalign),  32'd0);
        checkOutput({tag, "_st_busy"},      32'(st_busy),      32'd0);
        checkOutput({tag, "_mem_req"},      32'(mem_req),      32'd0);
        checkOutput({tag, "_mem_addr"},     mem_addr,          32'd0);
        checkOutput({tag, "_mem_wdata"},    mem_wdata,         32'd0);
        checkOutput({tag, "_mem_wstrb"},    32'(mem_wstrb),    32'd0);
        checkOutput({tag, "_bus_err"},      32'(bus_err),      32'd0);
        checkOutput({tag, "_bus_err_addr"}, bus_err_addr,      32'd0);
    endtask

    // One store through the whole path; aligned stores are acked after two wait cycles.
    task automatic applyStimulus(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        drive_store(v.addr, v.data, v.fn3);
        tick();
        st_valid = 1'b0;
        checkOutput({tag, "_misalign"}, 32'(st_misalign), 32'(v.mis));
        checkOutput({tag, "_req_early"}, 32'(mem_req), 32'd0);
        tick();
        if (!v.mis) begin
            checkOutput({tag, "_req"},   32'(mem_req), 32'd1);
            checkOutput({tag, "_addr"},  mem_addr,     v.exp_addr);
            checkOutput({tag, "_wdata"}, mem_wdata,    v.exp_wdata);
            checkOutput({tag, "_wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
            tick();
            tick();
            checkOutput({tag, "_req_held"},   32'(mem_req), 32'd1);
            checkOutput({tag, "_wdata_held"}, mem_wdata,    v.exp_wdata);
            mem_ack = 1'b1;
            tick();
            mem_ack = 1'b0;
            checkOutput({tag, "_req_done"},  32'(mem_req), 32'd0);
            checkOutput({tag, "_busy_done"}, 32'(st_busy), 32'd0);
        end else begin
            checkOutput({tag, "_misalign_once"}, 32'(st_misalign), 32'd0);
            checkOutput({tag, "_no_req"},        32'(mem_req),     32'd0);
            checkOutput({tag, "_no_busy"},       32'(st_busy),     32'd0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_1001, 32'h0000_00AB, 3'd0, 1'b0, 32'h0000_1000, 32'hABAB_ABAB, 4'b0100};
        vecs[1] = '{32'h0000_2002, 32'h0000_1234, 3'd1, 1'b0, 32'h0000_2000, 32'h0000_3412, 4'b0011};
        vecs[2] = '{32'h0000_2000, 32'h1122_3344, 3'd2, 1'b0, 32'h0000_2000, 32'h4433_2211, 4'b1111};
        vecs[3] = '{32'h0000_3001, 32'h1122_3344, 3'd2, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[4] = '{32'h0000_3003, 32'h0000_5566, 3'd1, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[5] = '{32'h0000_2000, 32'hBEEF_1234, 3'd1, 1'b0, 32'h0000_2000, 32'h3412_0000, 4'b1100};
        vecs[6] = '{32'h0000_5003, 32'h0000_00CD, 3'd4, 1'b0, 32'h0000_5000, 32'hCDCD_CDCD, 4'b0001};
        vecs[7] = '{32'h0000_6000, 32'hA1B2_C3D4, 3'd3, 1'b0, 32'h0000_6000, 32'hD4C3_B2A1, 4'b1111};
        vecs[8] = '{32'h0000_7001, 32'h0000_BEEF, 3'd5, 1'b1, 32'h0,         32'h0,         4'b0000};
        vecs[9] = '{32'h0000_8000, 32'h1234_5678, 3'd0, 1'b0, 32'h0000_8000, 32'h7878_7878, 4'b1000};

        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_fn3   = '0;
        mem_ack  = 1'b0;
        mem_err  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_reset_values("reset");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // FIFO fill with ack held low, then back-to-back drain in order.
        drive_store(32'h0000_0100, 32'h0102_0304, 3'd2);
        tick();
        checkOutput("fill_ready1", 32'(st_ready), 32'd1);
        drive_store(32'h0000_0104, 32'h0506_0708, 3'd2);
        tick();
        checkOutput("fill_ready_full", 32'(st_ready), 32'd0);
        checkOutput("fill_req", 32'(mem_req), 32'd1);
        checkOutput("fill_addr0", mem_addr, 32'h0000_0100);
        drive_store(32'h0000_0108, 32'h090A_0B0C, 3'd2);
        tick();
        checkOutput("fill_ready_still_full", 32'(st_ready), 32'd0);
        checkOutput("fill_addr0_held", mem_addr, 32'h0000_0100);
        mem_ack = 1'b1;
        tick();
        checkOutput("fill_ready_back", 32'(st_ready), 32'd1);
        checkOutput("fill_req_b2b", 32'(mem_req), 32'd1);
        checkOutput("fill_addr1", mem_addr, 32'h0000_0104);
        checkOutput("fill_wdata1", mem_wdata, 32'h0807_0605);
        tick();
        st_valid = 1'b0;
        checkOutput("fill_req_b2b2", 32'(mem_req), 32'd1);
        checkOutput("fill_addr2", mem_addr, 32'h0000_0108);
        checkOutput("fill_wdata2", mem_wdata, 32'h0C0B_0A09);
        tick();
        mem_ack = 1'b0;
        checkOutput("fill_req_end", 32'(mem_req), 32'd0);
        checkOutput("fill_busy_end", 32'(st_busy), 32'd0);

        // Bus error on the first of two queued stores.
        drive_store(32'h0000_4000, 32'hDEAD_BEEF, 3'd2);
        tick();
        drive_store(32'h0000_4004, 32'hCAFE_F00D, 3'd2);
        tick();
        st_valid = 1'b0;
        checkOutput("err_addr0", mem_addr, 32'h0000_4000);
        mem_ack = 1'b1;
        mem_err = 1'b1;
        tick();
        mem_ack = 1'b0;
        mem_err = 1'b0;
        checkOutput("err_pulse", 32'(bus_err), 32'd1);
        checkOutput("err_addr", bus_err_addr, 32'h0000_4000);
        checkOutput("err_next_req", 32'(mem_req), 32'd1);
        checkOutput("err_next_addr", mem_addr, 32'h0000_4004);
        tick();
        checkOutput("err_pulse_end", 32'(bus_err), 32'd0);
        checkOutput("err_addr_hold", bus_err_addr, 32'h0000_4000);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("err_drain_req", 32'(mem_req), 32'd0);
        checkOutput("err_drain_buserr", 32'(bus_err), 32'd0);

        // Reset while a request is outstanding and a second entry is queued.
        drive_store(32'h0000_9000, 32'h1111_1111, 3'd2);
        tick();
        drive_store(32'h0000_9004, 32'h2222_2222, 3'd2);
        tick();
        st_valid = 1'b0;
        checkOutput("rst_pre_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_values("midrst");
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        checkOutput("late_ack_req", 32'(mem_req), 32'd0);
        checkOutput("late_ack_busy", 32'(st_busy), 32'd0);
        checkOutput("late_ack_buserr", 32'(bus_err), 32'd0);
        tick();
        checkOutput("late_ack_idle", 32'(mem_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_unit.md
# store_unit

Store path between the core's execute stage and the data memory bus: accepts store requests, converts register data to the bus's byte-swapped lane order, generates byte strobes, and posts stores through a small FIFO. It is the write-side counterpart of the load-data adjuster and uses the same lane convention. Bus lane 0 (`[31:24]`) holds the byte at address offset 0; multi-byte values are stored least-significant byte first. Misaligned stores are rejected with a one-cycle flag and never reach the bus.

## Interface
- `DEPTH`, 2: store FIFO entries; power of two, ≥2.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `st_valid` in 1: store request valid.
- `st_ready` out 1: request accepted when `st_valid & st_ready`; equals `!full`.
- `st_addr` in 32: byte address.
- `st_data` in 32: register data, little-endian value.
- `st_fn3` in 3: funct3; only `[1:0]` is used: 0=byte, 1=half, 2/3=word.
- `st_misalign` out 1: one-cycle pulse, accepted request was misaligned and dropped.
- `st_busy` out 1: FIFO non-empty or bus request outstanding (used for fence/drain).
- `mem_req` out 1: bus write request.
- `mem_ack` in 1: bus completion, one cycle.
- `mem_err` in 1: qualifies `mem_ack`; the write failed.
- `mem_addr` out 32: word address, `[1:0]` always 0.
- `mem_wdata` out 32: lane-ordered write data.
- `mem_wstrb` out 4: bit 3 = lane `[31:24]` … bit 0 = lane `[7:0]`.
- `bus_err` out 1: one-cycle pulse on `mem_ack & mem_err`.
- `bus_err_addr` out 32: `mem_addr` of the failed write; held until the next error.

## Operation
- Format, by `a = st_addr[1:0]`, with `d = st_data`:
  - Byte: `d[7:0]` is replicated on all lanes; strobe `4'b1000 >> a`.
  - Half at `a=0`: `wdata = {d[7:0], d[15:8], 16'h0}`, strobe `1100`.
  - Half at `a=2`: `wdata = {16'h0, d[7:0], d[15:8]}`, strobe `0011`.
  - Word at `a=0`: `wdata = {d[7:0], d[15:8], d[23:16], d[31:24]}`, strobe `1111`.
  - Unused lanes of a half-word are 0.
- Misaligned cases are a half with `a[0]=1` and a word with `a!=0`. The request is still accepted (`st_ready` unaffected) but nothing is pushed. `st_misalign` is registered and pulses the cycle after acceptance.
- Aligned requests push `{addr[31:2], wdata, wstrb}` into the FIFO.
- Bus FSM:
  - IDLE → REQ when the FIFO is non-empty.
  - REQ: `mem_req=1` and `mem_*` are driven from the FIFO head, stable until `mem_ack`.
  - On `mem_ack` the head is popped. The FSM stays in REQ if another entry remains (back-to-back, with new payload the next cycle), else goes to IDLE.
- A bus error does not stall or retry; the store is dropped after the `bus_err` pulse.
- Full FIFO: `st_ready=0` even if a pop occurs in the same cycle; there is no same-cycle pass-through.
- Simultaneous push and pop when not full: both take effect and the count is unchanged.
- Pointers wrap modulo `DEPTH`; count width is `$clog2(DEPTH)+1`.

## Timing
- Reset values: `st_ready=1`, `st_misalign=0`, `st_busy=0`, `mem_req=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wstrb=0`, `bus_err=0`, `bus_err_addr=0`. The FIFO is emptied and the FSM is in IDLE.
- Latency: acceptance at edge N puts the entry in the FIFO; `mem_req` rises in cycle N+1.
- `mem_ack` is only sampled while `mem_req=1`; an ack arriving in IDLE is ignored.
- Reset mid-transfer: `mem_req` is low the cycle after reset, and the in-flight store is lost. The bus must tolerate an abandoned request.
- `st_busy` deasserts in the cycle after the last ack.

## Structure
- Shared package `srv1_pkg` holds:
  - `mem_size_e` (BYTE/HALF/WORD).
  - `wstrb_t` (logic [3:0]).
  - `store_entry_t` struct `{addr_w[29:0], wdata, wstrb}`.
  - Lane-order constants shared with the load adjuster.
- Sub-module `output_adj`: combinational formatter (`data_in`, `fn3`, `addr_low` → `wdata`, `wstrb`, `misalign`). It mirrors the load adjuster and is unit-testable alone.
- The FIFO and FSM live in `store_unit`.

## Test plan
- Byte store `addr=0x1001`, `data=0xAB`, ack after 2 cycles:
  - `mem_req` is asserted at N+1 and held until the ack.
  - `mem_addr=0x1000`, `wdata=0xABABABAB`, `wstrb=0100`.
- Half `addr=0x2002`, `data=0x1234` → `wdata=0x00003412`, `wstrb=0011`. Word `addr=0x2000`, `data=0x11223344` → `wdata=0x44332211`, `wstrb=1111`.
- Word at `0x3001` and half at `0x3003` → `st_misalign` pulses once each, and there is no `mem_req`.
- Ack held low with 3 stores issued (`DEPTH=2`):
  - `st_ready` drops after 2 accepts.
  - The ack pops the head and `st_ready` returns the next cycle.
  - All 3 stores complete in order, back-to-back.
- `mem_ack` with `mem_err` on the write to `0x4000` → `bus_err` pulses for one cycle, `bus_err_addr=0x4000`, and the next queued store proceeds.
- Reset asserted while `mem_req=1` with 2 entries queued:
  - All outputs take their reset values the next cycle.
  - A late `mem_ack` is ignored and `st_busy=0`.
